// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler owning the select of a shared 8:1 W-bit mux.
// Grants one requester at a time for up to BURST valid/ready transfers.
module mux8_rr_sched #(
  parameter int unsigned W     = 4,
  parameter int unsigned BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  input  logic [W-1:0] d [7:0],
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [2:0]   sel,
  output logic [7:0]   gnt,
  output logic [3:0]   beat_cnt
);

  localparam logic [3:0] BURST_L = 4'(BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx, sel_nx;
  logic [7:0] gnt_nx;
  logic [3:0] beat_nx, beat_inc;
  logic       valid_nx, xfer;
  logic       found;
  logic [2:0] base, scan, pick_idx;

  assign out_data = d[sel];
  assign xfer     = out_valid & out_ready;

  // First requester after base, wrapping; base is ptr in IDLE, sel on release.
  always_comb begin
    base     = (state == GRANT) ? sel : ptr;
    found    = 1'b0;
    pick_idx = 3'd0;
    scan     = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      scan = 3'(base + 3'(k));
      if (!found && req[scan]) begin
        found    = 1'b1;
        pick_idx = scan;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    gnt_nx   = gnt;
    beat_nx  = beat_cnt;
    valid_nx = out_valid;
    beat_inc = 4'(beat_cnt + 4'd1);
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          sel_nx   = pick_idx;
          gnt_nx   = 8'b1 << pick_idx;
          beat_nx  = 4'd0;
          valid_nx = 1'b1;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (beat_inc < BURST_L && req[sel]) begin
            beat_nx = beat_inc;
          end else begin
            ptr_nx = sel;
            // Search from sel+1 naturally falls back to sel for a lone requester.
            if (found) begin
              sel_nx  = pick_idx;
              gnt_nx  = 8'b1 << pick_idx;
              beat_nx = 4'd0;
            end else begin
              state_nx = IDLE;
              gnt_nx   = 8'd0;
              beat_nx  = 4'd0;
              valid_nx = 1'b0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd7;
      sel       <= 3'd0;
      gnt       <= 8'd0;
      beat_cnt  <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      sel       <= sel_nx;
      gnt       <= gnt_nx;
      beat_cnt  <= beat_nx;
      out_valid <= valid_nx;
    end
  end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: BURST=4 and BURST=1 instances share stimulus,
// a per-instance owner/count/pointer model is compared every cycle.
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;
  logic [3:0] d [7:0];

  logic       ov [2];
  logic [3:0] od [2];
  logic [2:0] sl [2];
  logic [7:0] gn [2];
  logic [3:0] bc [2];

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 when idle), transfers in this grant, priority pointer.
  int m_own [2] = '{-1, -1};
  int m_cnt [2] = '{0, 0};
  int m_ptr [2] = '{7, 7};
  int burst [2] = '{4, 1};

  always #5 clk = ~clk;

  mux8_rr_sched #(.W(4), .BURST(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .d(d), .out_ready(out_ready),
    .out_valid(ov[0]), .out_data(od[0]), .sel(sl[0]), .gnt(gn[0]), .beat_cnt(bc[0])
  );

  mux8_rr_sched #(.W(4), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .d(d), .out_ready(out_ready),
    .out_valid(ov[1]), .out_data(od[1]), .sel(sl[1]), .gnt(gn[1]), .beat_cnt(bc[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_after(input int from);
    for (int k = 1; k <= 8; k++)
      if (req[(from + k) % 8]) return (from + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_own[i] = -1; m_cnt[i] = 0; m_ptr[i] = 7;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_own[i] < 0) begin
          if (req != 8'h00) begin
            m_own[i] = next_after(m_ptr[i]);
            m_cnt[i] = 0;
          end
        end else if (out_ready) begin
          m_cnt[i]++;
          if (!(m_cnt[i] < burst[i] && req[m_own[i]])) begin
            m_ptr[i] = m_own[i];
            m_own[i] = next_after(m_own[i]);
            m_cnt[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_valid", i), int'(ov[i]), int'(m_own[i] >= 0));
      chk($sformatf("u%0d_gnt", i), int'(gn[i]), (m_own[i] >= 0) ? (1 << m_own[i]) : 0);
      if (m_own[i] >= 0) begin
        chk($sformatf("u%0d_sel", i), int'(sl[i]), m_own[i]);
        chk($sformatf("u%0d_beat", i), int'(bc[i]), m_cnt[i]);
        chk($sformatf("u%0d_data", i), int'(od[i]), 8 | m_own[i]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) d[i] = 4'(8 | i);

    // Reset values
    tick(2);
    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_gnt", int'(gn[0]), 0);
    chk("rst_sel", int'(sl[0]), 0);
    chk("rst_beat", int'(bc[0]), 0);

    // Single request to 3, lone requester keeps streaming
    rst = 1'b0; req = 8'h08; out_ready = 1'b1;
    tick(1);
    chk("single_sel", int'(sl[0]), 3);
    chk("single_gnt", int'(gn[0]), 8'h08);
    chk("single_data", int'(od[0]), 4'hB);
    tick(3);
    chk("single_beat3", int'(bc[0]), 3);
    tick(1);
    chk("single_regrant_beat", int'(bc[0]), 0);
    chk("single_regrant_gnt", int'(gn[0]), 8'h08);
    req = 8'h00;
    tick(1);
    chk("single_idle", int'(ov[0]), 0);

    // Full round robin on the BURST=1 instance
    pulse_rst();
    req = 8'hFF; out_ready = 1'b1;
    tick(1);
    for (int c = 0; c < 9; c++) begin
      chk("rr_sel", int'(sl[1]), c % 8);
      chk("rr_data", int'(od[1]), 8 | (c % 8));
      tick(1);
    end

    // Burst limit on the BURST=4 instance
    pulse_rst();
    req = 8'h05; out_ready = 1'b1;
    tick(1);
    for (int c = 0; c < 8; c++) begin
      chk("burst_sel", int'(sl[0]), (c < 4) ? 0 : 2);
      chk("burst_beat", int'(bc[0]), c % 4);
      tick(1);
    end
    chk("burst_back_sel", int'(sl[0]), 0);
    chk("burst_back_beat", int'(bc[0]), 0);

    // Backpressure: grant held while req[5] drops, one transfer then idle
    pulse_rst();
    req = 8'h20; out_ready = 1'b0;
    tick(1);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) req = 8'h00;
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_sel", int'(sl[0]), 5);
      chk("bp_gnt", int'(gn[0]), 8'h20);
      tick(1);
    end
    out_ready = 1'b1;
    tick(1);
    chk("bp_idle_valid", int'(ov[0]), 0);
    chk("bp_idle_gnt", int'(gn[0]), 0);

    // Wrap-around: after releasing 6, requester 0 beats 6
    pulse_rst();
    req = 8'h40; out_ready = 1'b1;
    tick(1);
    chk("wrap_first", int'(sl[0]), 6);
    req = 8'h00;
    tick(1);
    req = 8'h41;
    tick(1);
    chk("wrap_sel0", int'(sl[0]), 0);
    chk("wrap_sel1", int'(sl[1]), 0);
    req = 8'h00;
    tick(2);

    // Reset mid-burst on requester 4
    pulse_rst();
    req = 8'h10; out_ready = 1'b1;
    tick(1);
    chk("mid_sel", int'(sl[0]), 4);
    tick(2);
    chk("mid_beat2", int'(bc[0]), 2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(ov[0]), 0);
    chk("mid_rst_gnt", int'(gn[0]), 0);
    chk("mid_rst_sel", int'(sl[0]), 0);
    chk("mid_rst_beat", int'(bc[0]), 0);
    req = 8'h11;
    rst = 1'b0;
    tick(1);
    chk("mid_after_sel", int'(sl[0]), 0);
    chk("mid_after_gnt", int'(gn[0]), 8'h01);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares one 4-bit, 8-input multiplexed channel between eight requesters. It owns the 3-bit select of the shared 8:1 mux and grants one requester at a time. It presents the selected word downstream with a valid/ready handshake. A granted requester may keep the channel for a bounded burst before the grant rotates.

## Interface
- `W`, default 4: data width per input.
- `BURST`, default 4: maximum consecutive transfers per grant (1..15).
- Clock is `clk`; reset is `rst`. There is one clock. Reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  per-requester request; bit i corresponds to input `d[i]`.
- `d`  in  8 x W  unpacked array `d[7:0]` of W-bit input words.
- `out_ready`  in  1  downstream accepts the current word.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  W  equals `d[sel]` (combinational through the mux).
- `sel`  out  3  registered mux select, the index of the current grantee.
- `gnt`  out  8  registered one-hot grant; all zero when idle.
- `beat_cnt`  out  4  transfers completed in the current grant.

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If `req` is nonzero, pick the first set bit searching from `ptr+1` upward, wrapping 7 -> 0.
  - Load `sel`, set `gnt[sel]`, clear `beat_cnt`, and go to GRANT.
  - With no requests, stay in IDLE.
- GRANT:
  - `out_valid` = 1.
  - A transfer occurs on any cycle with `out_valid && out_ready`.
- On a transfer, `beat_cnt` increments. Then:
  - Continue: if the new count < BURST and `req[sel]` is 1, stay in GRANT with the same `sel`.
  - Release: otherwise set `ptr <= sel`.
    - If any `req` bit other than `sel` is 1, grant the next requester from `sel+1` in the same edge. This gives back-to-back grants with no idle cycle.
    - Else, if `req[sel]` is still 1, re-grant `sel` with `beat_cnt` = 0. A lone requester keeps streaming.
    - Else go to IDLE.
- No transfer: `sel`, `gnt` and `out_valid` hold, and `out_data` tracks `d[sel]`.
  - Deasserting `req[sel]` without a transfer does not revoke the grant. The word, once offered, stays offered until accepted.
- Priority pointer `ptr` resets to 7, so requester 0 wins first.
- A requester whose `req` rises while another holds the grant waits. Its bit is considered only at the next release or IDLE decision.
- `gnt` is always one-hot or zero, and equals `1 << sel` whenever `out_valid` = 1.

## Timing
- Reset values (asynchronous, immediate): `out_valid` = 0, `gnt` = 0, `sel` = 0, `beat_cnt` = 0, `ptr` = 7, state IDLE.
- `out_data` shows `d[0]` during reset; it is don't-care while `out_valid` = 0.
- Request-to-valid latency: `req` seen high at edge t in IDLE gives `out_valid`/`gnt` high after edge t (one cycle).
- Release-to-next-grant: zero bubble. The new `sel` is valid in the cycle after the final transfer.
- Maximum throughput is one transfer per cycle while `out_ready` = 1.
- `rst` asserted mid-grant clears everything at once, with no partial transfer completion. After deassertion, arbitration restarts from requester 0.
- Fairness: with all 8 requesting continuously and `out_ready` = 1, each requester receives exactly BURST transfers per 8*BURST cycles.

## Test plan
- Single request: set `d[i]` = 4'b1000|i and `req` = 8'h08. Expect `sel`=3, `gnt`=8'h08, `out_data`=4'b1011 one cycle later. With `out_ready`=1 and BURST=4, the grant is re-issued to 3 continuously.
- Full round robin: `req`=8'hFF, `out_ready`=1, BURST=1. `sel` sequence is 0,1,2,...,7,0 on consecutive cycles, and `out_data` runs 4'b1000..4'b1111.
- Burst limit: `req`=8'h05, BURST=4, `out_ready`=1. Expect 4 beats from 0 (`beat_cnt` 0..3), then 4 from 2, then back to 0.
- Backpressure: grant to 5 with `out_ready`=0 for 6 cycles, dropping `req[5]` in cycle 2. `out_valid`, `sel`=5 and `gnt`=8'h20 hold. The first cycle with `out_ready`=1 completes one transfer, then the block goes to IDLE.
- Wrap-around: `ptr`=6 after a grant to 6, then `req`=8'h41. Next grant goes to 0, not 6.
- Reset mid-burst: assert `rst` during `beat_cnt`=2 on requester 4. All outputs go 0 immediately, and after release `req`=8'h11 grants 0 first.
